mode_accum_reg: RTL and testbench

- Parametrised successor of the team's 16-bit sync-clear/clock-enable register, built as the multiplier datapath's accumulator.
- Holds, loads, accumulates or shift-accumulates partial products under a 2-bit mode.
- Sticky overflow flag, optional saturation, and a configurable output pipeline with a valid flag.
- Sits between the partial-product generator and the product output of the sequential multiplier.

---
 rtl/mode_accum_reg_if.sv | 26 ++
 rtl/mode_accum_reg.sv | 90 +++++++++
 tb/tb_mode_accum_reg.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mode_accum_reg_if.sv
// Operand/control/result bundle between the partial-product generator and
// the mode_accum_reg accumulator.
interface mode_accum_reg_if #(
  parameter int WIDTH    = 16,
  parameter int IN_WIDTH = 16
);
  logic                sclr_n;
  logic                clk_ena;
  logic [1:0]          mode;
  logic                in_valid;
  logic [IN_WIDTH-1:0] datain;
  logic [WIDTH-1:0]    reg_out;
  logic                out_valid;
  logic                ovf;
  logic                zero;

  modport master (
    output sclr_n, clk_ena, mode, in_valid, datain,
    input  reg_out, out_valid, ovf, zero
  );

  modport slave (
    input  sclr_n, clk_ena, mode, in_valid, datain,
    output reg_out, out_valid, ovf, zero
  );
endinterface

// File: rtl/mode_accum_reg.sv
// Multiplier accumulator: hold/load/accumulate/shift-accumulate with sticky
// overflow, optional saturation and a PIPE-deep output pipeline.
module mode_accum_reg #(
  parameter int WIDTH    = 16,
  parameter int IN_WIDTH = 16,
  parameter int SHIFT    = 4,
  parameter int SATURATE = 0,
  parameter int PIPE     = 1
) (
  input logic              clk,
  input logic              aclr,
  mode_accum_reg_if.slave  bus
);
  localparam int FW = WIDTH + SHIFT + 1;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_ACC   = 2'b10;
  localparam logic [1:0] MODE_SHACC = 2'b11;

  // Index 0 is the accumulator itself; index PIPE drives the outputs.
  logic [WIDTH-1:0] r_stage_d [0:PIPE];
  logic             r_stage_v [0:PIPE];
  logic             r_ovf;

  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH:0]   w_sum_acc;
  logic [FW-1:0]    w_sum_shift;
  logic             w_op;
  logic [WIDTH-1:0] w_next;
  logic             w_ovf_op;

  assign w_acc       = r_stage_d[0];
  assign w_d         = WIDTH'(bus.datain);
  assign w_sum_acc   = {1'b0, w_acc} + {1'b0, w_d};
  assign w_sum_shift = ({{(SHIFT+1){1'b0}}, w_acc} << SHIFT) + FW'(w_d);
  assign w_op        = bus.in_valid && (bus.mode != MODE_HOLD);

  always_comb begin
    w_next   = w_acc;
    w_ovf_op = 1'b0;
    if (w_op) begin
      case (bus.mode)
        MODE_LOAD: w_next = w_d;
        MODE_ACC: begin
          w_next   = w_sum_acc[WIDTH-1:0];
          w_ovf_op = w_sum_acc[WIDTH];
        end
        MODE_SHACC: begin
          w_next   = w_sum_shift[WIDTH-1:0];
          w_ovf_op = |w_sum_shift[FW-1:WIDTH];
        end
        default: w_next = w_acc;
      endcase
      if ((SATURATE != 0) && w_ovf_op) begin
        w_next = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i <= PIPE; i++) begin
        r_stage_d[i] <= '0;
        r_stage_v[i] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (!bus.sclr_n) begin
      for (int i = 0; i <= PIPE; i++) begin
        r_stage_d[i] <= '0;
        r_stage_v[i] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (bus.clk_ena) begin
      r_stage_d[0] <= w_next;
      r_stage_v[0] <= w_op;
      for (int i = 1; i <= PIPE; i++) begin
        r_stage_d[i] <= r_stage_d[i-1];
        r_stage_v[i] <= r_stage_v[i-1];
      end
      r_ovf <= r_ovf | w_ovf_op;
    end
  end

  assign bus.reg_out   = r_stage_d[PIPE];
  assign bus.out_valid = r_stage_v[PIPE];
  assign bus.ovf       = r_ovf;
  assign bus.zero      = (r_stage_d[PIPE] == '0);
endmodule

// File: tb/tb_mode_accum_reg.sv
// Scoreboard bench for mode_accum_reg: a wrapping instance (checked every
// enabled cycle) and a saturating twin driven with identical stimulus.
module tb_mode_accum_reg;
  localparam int PIPE = 1;

  typedef struct packed {
    logic        v;
    logic [15:0] val;
  } exp_t;

  logic clk;
  logic aclr;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t mon_e;

  mode_accum_reg_if #(.WIDTH(16), .IN_WIDTH(16)) f ();
  mode_accum_reg_if #(.WIDTH(16), .IN_WIDTH(16)) s ();

  mode_accum_reg #(.WIDTH(16), .IN_WIDTH(16), .SHIFT(4), .SATURATE(0), .PIPE(PIPE)) dut (
    .clk(clk), .aclr(aclr), .bus(f)
  );
  mode_accum_reg #(.WIDTH(16), .IN_WIDTH(16), .SHIFT(4), .SATURATE(1), .PIPE(PIPE)) dut_sat (
    .clk(clk), .aclr(aclr), .bus(s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop one expectation per enabled, non-cleared edge and compare the outputs.
  always @(posedge clk) begin
    if (!aclr && f.sclr_n === 1'b1 && f.clk_ena === 1'b1) begin
      #1;
      if (q.size() > PIPE) begin
        mon_e = q.pop_front();
        checks++;
        if (f.out_valid !== mon_e.v) begin
          errors++;
          $display("FAIL sb_out_valid: got %b expected %b at %0t", f.out_valid, mon_e.v, $time);
        end
        checks++;
        if (f.reg_out !== mon_e.val) begin
          errors++;
          $display("FAIL sb_reg_out: got %h expected %h at %0t", f.reg_out, mon_e.val, $time);
        end
        checks++;
        if (f.zero !== (mon_e.val == 16'h0000)) begin
          errors++;
          $display("FAIL sb_zero: got %b expected %b at %0t", f.zero, (mon_e.val == 16'h0000), $time);
        end
      end
    end
  end

  task automatic set_in(input logic sn, input logic en, input logic [1:0] m,
                        input logic v, input logic [15:0] d);
    f.sclr_n = sn; f.clk_ena = en; f.mode = m; f.in_valid = v; f.datain = d;
    s.sclr_n = sn; s.clk_ena = en; s.mode = m; s.in_valid = v; s.datain = d;
  endtask

  // Drive one enabled cycle and queue the expected stage-0 result.
  task automatic drive(input logic [1:0] m, input logic v, input logic [15:0] d,
                       input logic [15:0] exp_val);
    exp_t e;
    set_in(1'b1, 1'b1, m, v, d);
    e.v   = v && (m != 2'b00);
    e.val = exp_val;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic restart_queue();
    exp_t e;
    q.delete();
    e.v   = 1'b0;
    e.val = 16'h0000;
    q.push_back(e);
  endtask

  task automatic do_sclr();
    set_in(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000);
    @(negedge clk);
    restart_queue();
    set_in(1'b1, 1'b1, 2'b00, 1'b0, 16'h0000);
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    set_in(1'b1, 1'b1, 2'b00, 1'b0, 16'h0000);
    #12;
    checks++; if (f.reg_out !== 16'h0000) begin errors++; $display("FAIL rst_reg_out: got %h expected 0000", f.reg_out); end
    checks++; if (f.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", f.out_valid); end
    checks++; if (f.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", f.ovf); end
    checks++; if (f.zero !== 1'b1) begin errors++; $display("FAIL rst_zero: got %b expected 1", f.zero); end
    @(negedge clk);
    aclr = 1'b0;
    restart_queue();
    drive(2'b01, 1'b1, 16'hAC53, 16'hAC53);
    drive(2'b00, 1'b0, 16'h0000, 16'hAC53);
    #2 aclr = 1'b1;
    #1;
    checks++; if (f.reg_out !== 16'h0000) begin errors++; $display("FAIL aclr_reg_out: got %h expected 0000", f.reg_out); end
    checks++; if (f.out_valid !== 1'b0) begin errors++; $display("FAIL aclr_out_valid: got %b expected 0", f.out_valid); end
    checks++; if (f.ovf !== 1'b0) begin errors++; $display("FAIL aclr_ovf: got %b expected 0", f.ovf); end
    checks++; if (f.zero !== 1'b1) begin errors++; $display("FAIL aclr_zero: got %b expected 1", f.zero); end
    #1 aclr = 1'b0;
    restart_queue();
  endtask

  task automatic test_load_latency();
    do_sclr();
    drive(2'b01, 1'b1, 16'hAC53, 16'hAC53);
    checks++; if (f.out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b expected 0", f.out_valid); end
    drive(2'b00, 1'b0, 16'h0000, 16'hAC53);
    drive(2'b00, 1'b0, 16'h0000, 16'hAC53);
  endtask

  task automatic test_accum_ovf();
    do_sclr();
    drive(2'b01, 1'b1, 16'hFFF0, 16'hFFF0);
    checks++; if (f.ovf !== 1'b0) begin errors++; $display("FAIL ovf_after_load: got %b expected 0", f.ovf); end
    drive(2'b10, 1'b1, 16'h0020, 16'h0010);
    checks++; if (f.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", f.ovf); end
    drive(2'b10, 1'b1, 16'h0001, 16'h0011);
    checks++; if (f.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", f.ovf); end
    checks++; if (s.reg_out !== 16'hFFFF) begin errors++; $display("FAIL sat_reg_out: got %h expected FFFF", s.reg_out); end
    checks++; if (s.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", s.ovf); end
    drive(2'b00, 1'b0, 16'h0000, 16'h0011);
    checks++; if (s.reg_out !== 16'hFFFF) begin errors++; $display("FAIL sat_reg_out2: got %h expected FFFF", s.reg_out); end
    drive(2'b00, 1'b0, 16'h0000, 16'h0011);
  endtask

  task automatic test_shift_acc();
    do_sclr();
    drive(2'b01, 1'b1, 16'h0001, 16'h0001);
    drive(2'b11, 1'b1, 16'h0002, 16'h0012);
    drive(2'b11, 1'b1, 16'h0003, 16'h0123);
    drive(2'b11, 1'b1, 16'h0004, 16'h1234);
    checks++; if (f.ovf !== 1'b0) begin errors++; $display("FAIL shacc_no_ovf: got %b expected 0", f.ovf); end
    drive(2'b11, 1'b1, 16'h0005, 16'h2345);
    checks++; if (f.ovf !== 1'b1) begin errors++; $display("FAIL shacc_ovf: got %b expected 1", f.ovf); end
    drive(2'b00, 1'b0, 16'h0000, 16'h2345);
  endtask

  task automatic test_stall_clear();
    do_sclr();
    drive(2'b01, 1'b1, 16'hFFFF, 16'hFFFF);
    drive(2'b10, 1'b1, 16'h0002, 16'h0001);
    set_in(1'b1, 1'b0, 2'b10, 1'b1, 16'h0007);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (f.reg_out !== 16'hFFFF) begin errors++; $display("FAIL stall_reg_out[%0d]: got %h expected FFFF", i, f.reg_out); end
      checks++; if (f.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, f.out_valid); end
      checks++; if (f.ovf !== 1'b1) begin errors++; $display("FAIL stall_ovf[%0d]: got %b expected 1", i, f.ovf); end
    end
    set_in(1'b0, 1'b0, 2'b10, 1'b1, 16'h0007);
    @(negedge clk);
    checks++; if (f.reg_out !== 16'h0000) begin errors++; $display("FAIL sclr_reg_out: got %h expected 0000", f.reg_out); end
    checks++; if (f.out_valid !== 1'b0) begin errors++; $display("FAIL sclr_valid: got %b expected 0", f.out_valid); end
    checks++; if (f.ovf !== 1'b0) begin errors++; $display("FAIL sclr_ovf: got %b expected 0", f.ovf); end
    restart_queue();
    drive(2'b00, 1'b0, 16'h0000, 16'h0000);
    drive(2'b00, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic test_bubbles();
    do_sclr();
    drive(2'b01, 1'b1, 16'h0055, 16'h0055);
    drive(2'b00, 1'b1, 16'h1234, 16'h0055);
    drive(2'b10, 1'b0, 16'h1111, 16'h0055);
    drive(2'b00, 1'b0, 16'h0000, 16'h0055);
    drive(2'b00, 1'b0, 16'h0000, 16'h0055);
  endtask

  task automatic test_sclr_priority();
    do_sclr();
    drive(2'b01, 1'b1, 16'h0077, 16'h0077);
    set_in(1'b0, 1'b1, 2'b01, 1'b1, 16'h0099);
    @(negedge clk);
    checks++; if (f.reg_out !== 16'h0000) begin errors++; $display("FAIL sclr_pri_reg_out: got %h expected 0000", f.reg_out); end
    checks++; if (f.out_valid !== 1'b0) begin errors++; $display("FAIL sclr_pri_valid: got %b expected 0", f.out_valid); end
    restart_queue();
    drive(2'b00, 1'b0, 16'h0000, 16'h0000);
    drive(2'b00, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic test_back_to_back();
    logic [15:0] sum;
    do_sclr();
    sum = 16'h0000;
    drive(2'b01, 1'b1, 16'h0000, 16'h0000);
    for (int i = 1; i <= 6; i++) begin
      sum = sum + 16'(i);
      drive(2'b10, 1'b1, 16'(i), sum);
    end
    drive(2'b00, 1'b0, 16'h0000, sum);
    drive(2'b00, 1'b0, 16'h0000, sum);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_latency();
    test_accum_ovf();
    test_shift_acc();
    test_stall_clear();
    test_bubbles();
    test_sclr_priority();
    test_back_to_back();
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
